// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared selects and width/saturation helpers for the luma datapath
package datapath_pkg;

   localparam logic [1:0] COEF_R = 2'd0;
   localparam logic [1:0] COEF_G = 2'd1;
   localparam logic [1:0] COEF_B = 2'd2;

   // three products of pix_w+coef_w bits need two carry bits
   function automatic int sum_w(input int pix_w, input int coef_w);
      return pix_w + coef_w + 2;
   endfunction

   function automatic logic [31:0] saturate(input logic [31:0] val, input int pix_w);
      logic [31:0] lim;
      lim = (32'd1 << pix_w) - 32'd1;
      return (val > lim) ? lim : val;
   endfunction

endpackage

// File: rtl/luma_out_fifo.sv
// rtl/luma_out_fifo.sv - show-ahead output FIFO with occupancy count
// Output data reads as zero while empty so reset leaves the stream outputs clean.
module luma_out_fifo #(
   parameter int P_WIDTH = 9,
   parameter int P_DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [P_WIDTH-1:0]         i_wdata,
   input  logic                       i_pop,
   output logic [P_WIDTH-1:0]         o_rdata,
   output logic                       o_valid,
   output logic [$clog2(P_DEPTH):0]   o_count
);

   localparam int AW = $clog2(P_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(P_DEPTH);

   logic [P_WIDTH-1:0] mem_q [P_DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        cnt_q;
   logic               empty;
   logic               full;
   logic               wr_en;
   logic               rd_en;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == FULL_CNT);
   assign rd_en = i_pop & ~empty;
   assign wr_en = i_push & (~full | rd_en);

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         assert (!(i_push && full && !rd_en));
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign o_valid = ~empty;
   assign o_rdata = empty ? '0 : mem_q[rd_ptr_q];
   assign o_count = cnt_q;

endmodule

// File: rtl/datapath_luma.sv
// rtl/datapath_luma.sv - RGB to luma pipeline with programmable coefficients and credit flow control
// Define DATAPATH_LUMA_ROUND_EN for round-half-up before the shift; default truncates.
module datapath_luma
   import datapath_pkg::*;
#(
   parameter int P_PIX_W      = 8,
   parameter int P_COEF_W     = 8,
   parameter int P_COEF_R     = 77,
   parameter int P_COEF_G     = 150,
   parameter int P_COEF_B     = 29,
   parameter int P_FIFO_DEPTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_coef_wr,
   input  logic [1:0]            i_coef_sel,
   input  logic [P_COEF_W-1:0]   i_coef_data,
   input  logic [3*P_PIX_W-1:0]  data_in,
   input  logic                  valid_in,
   input  logic                  sof_in,
   output logic                  busy_out,
   output logic [P_PIX_W-1:0]    data_out,
   output logic                  valid_out,
   output logic                  sof_out,
   input  logic                  busy_in
);

   localparam int PROD_W = P_PIX_W + P_COEF_W;
   localparam int SUM_W  = sum_w(P_PIX_W, P_COEF_W);
   localparam int CNT_W  = $clog2(P_FIFO_DEPTH) + 1;
`ifdef DATAPATH_LUMA_ROUND_EN
   localparam logic [SUM_W-1:0] RND_C = SUM_W'(1) << (P_COEF_W - 1);
`else
   localparam logic [SUM_W-1:0] RND_C = '0;
`endif

   logic [P_COEF_W-1:0] coef_sh_q  [3];
   logic [P_COEF_W-1:0] coef_act_q [3];
   logic [P_COEF_W-1:0] coef_use   [3];

   logic                accept;
   logic                sof_acc;
   logic [PROD_W-1:0]   prod_r_d, prod_g_d, prod_b_d;
   logic [PROD_W-1:0]   prod_r_q, prod_g_q, prod_b_q;
   logic                s1_vld_q, s1_sof_q;
   logic [SUM_W-1:0]    sum_d, sum_q;
   logic                s2_vld_q, s2_sof_q;
   logic [SUM_W-1:0]    shifted;
   logic [P_PIX_W-1:0]  luma;
   logic                busy_d, busy_q;
   logic                pop;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [P_PIX_W:0]    fifo_rdata;
   int                  occ;

   assign accept  = valid_in & ~busy_q;
   assign sof_acc = accept & sof_in;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         coef_sh_q[0]  <= P_COEF_W'(P_COEF_R);
         coef_sh_q[1]  <= P_COEF_W'(P_COEF_G);
         coef_sh_q[2]  <= P_COEF_W'(P_COEF_B);
         coef_act_q[0] <= P_COEF_W'(P_COEF_R);
         coef_act_q[1] <= P_COEF_W'(P_COEF_G);
         coef_act_q[2] <= P_COEF_W'(P_COEF_B);
      end else begin
         if (i_coef_wr) begin
            case (i_coef_sel)
               COEF_R:  coef_sh_q[0] <= i_coef_data;
               COEF_G:  coef_sh_q[1] <= i_coef_data;
               COEF_B:  coef_sh_q[2] <= i_coef_data;
               default: ;
            endcase
         end
         if (sof_acc) begin
            coef_act_q <= coef_sh_q;
         end
      end
   end

   // the sof beat itself must already see the shadow values
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         coef_use[i] = sof_acc ? coef_sh_q[i] : coef_act_q[i];
      end
   end

   assign prod_r_d = PROD_W'(data_in[P_PIX_W-1:0])           * PROD_W'(coef_use[0]);
   assign prod_g_d = PROD_W'(data_in[2*P_PIX_W-1:P_PIX_W])   * PROD_W'(coef_use[1]);
   assign prod_b_d = PROD_W'(data_in[3*P_PIX_W-1:2*P_PIX_W]) * PROD_W'(coef_use[2]);

   assign sum_d = SUM_W'(prod_r_q) + SUM_W'(prod_g_q) + SUM_W'(prod_b_q) + RND_C;

   assign shifted = sum_q >> P_COEF_W;
   assign luma    = P_PIX_W'(saturate(32'(shifted), P_PIX_W));

   assign pop = valid_out & ~busy_in;

   // credit check on post-edge occupancy: FIFO after push/pop plus both pipeline stages
   always_comb begin
      occ    = int'(fifo_cnt) + int'(s2_vld_q) - int'(pop) + int'(accept) + int'(s1_vld_q);
      busy_d = (occ >= P_FIFO_DEPTH);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_vld_q <= 1'b0;
         s1_sof_q <= 1'b0;
         prod_r_q <= '0;
         prod_g_q <= '0;
         prod_b_q <= '0;
         s2_vld_q <= 1'b0;
         s2_sof_q <= 1'b0;
         sum_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         s1_vld_q <= accept;
         s1_sof_q <= sof_acc;
         prod_r_q <= prod_r_d;
         prod_g_q <= prod_g_d;
         prod_b_q <= prod_b_d;
         s2_vld_q <= s1_vld_q;
         s2_sof_q <= s1_sof_q;
         sum_q    <= sum_d;
         busy_q   <= busy_d;
      end
   end

   luma_out_fifo #(
      .P_WIDTH (P_PIX_W + 1),
      .P_DEPTH (P_FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (s2_vld_q),
      .i_wdata ({luma, s2_sof_q}),
      .i_pop   (pop),
      .o_rdata (fifo_rdata),
      .o_valid (valid_out),
      .o_count (fifo_cnt)
   );

   assign busy_out = busy_q;
   assign data_out = fifo_rdata[P_PIX_W:1];
   assign sof_out  = fifo_rdata[0];

endmodule

// File: tb/tb_datapath_luma.sv
// tb/tb_datapath_luma.sv - scoreboard bench for datapath_luma
module tb_datapath_luma;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_coef_wr;
   logic [1:0]  i_coef_sel;
   logic [7:0]  i_coef_data;
   logic [23:0] data_in;
   logic        valid_in;
   logic        sof_in;
   logic        busy_out;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        sof_out;
   logic        busy_in;

   int          total = 0;
   int          bad = 0;
   int          n_pop = 0;
   int          m_sh [3];
   int          m_act [3];
   logic [8:0]  sb [$];
   logic [8:0]  sb_e;

   always #5 clk = ~clk;

   datapath_luma dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_coef_wr   (i_coef_wr),
      .i_coef_sel  (i_coef_sel),
      .i_coef_data (i_coef_data),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .sof_in      (sof_in),
      .busy_out    (busy_out),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .sof_out     (sof_out),
      .busy_in     (busy_in)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_sh[0] = 77;  m_sh[1] = 150;  m_sh[2] = 29;
      m_act[0] = 77; m_act[1] = 150; m_act[2] = 29;
   endtask

   task automatic model_accept(input int r, input int g, input int b, input bit sof);
      int s;
      int y;
      if (sof) m_act = m_sh;
      s = r * m_act[0] + g * m_act[1] + b * m_act[2];
`ifdef DATAPATH_LUMA_ROUND_EN
      s = s + 128;
`endif
      y = s >> 8;
      if (y > 255) y = 255;
      sb.push_back({y[7:0], sof});
   endtask

   task automatic send(input int r, input int g, input int b, input bit sof,
                       input bit wr = 1'b0, input int sel = 0, input int wd = 0);
      bit acc;
      int n;
      data_in  = {b[7:0], g[7:0], r[7:0]};
      valid_in = 1'b1;
      sof_in   = sof;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = !busy_out;
         if (acc && wr) begin
            i_coef_wr   = 1'b1;
            i_coef_sel  = sel[1:0];
            i_coef_data = wd[7:0];
         end
         @(posedge clk);
         #1;
         n++;
      end
      valid_in  = 1'b0;
      sof_in    = 1'b0;
      i_coef_wr = 1'b0;
      chk("accept", acc, 1);
      if (acc) begin
         model_accept(r, g, b, sof);
         if (wr && sel < 3) m_sh[sel] = wd;
      end
   endtask

   task automatic coef_write(input int sel, input int wd);
      i_coef_wr   = 1'b1;
      i_coef_sel  = sel[1:0];
      i_coef_data = wd[7:0];
      @(posedge clk);
      #1;
      i_coef_wr = 1'b0;
      if (sel < 3) m_sh[sel] = wd;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drained", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (!rst && valid_out && !busy_in) begin
         chk("sb_has_entry", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            sb_e = sb.pop_front();
            chk("luma", data_out, sb_e[8:1]);
            chk("sof", sof_out, sb_e[0]);
            n_pop++;
         end
      end
   end

   initial begin
      bit acc;
      int n_acc;
      int pops0;
      rst = 1'b1;
      i_coef_wr = 1'b0;
      i_coef_sel = 2'd0;
      i_coef_data = 8'd0;
      data_in = '0;
      valid_in = 1'b0;
      sof_in = 1'b0;
      busy_in = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", valid_out, 0);
      chk("rst_sof", sof_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_busy", busy_out, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // white saturates, and the latency from the accept edge
      send(255, 255, 255, 1'b1);
      chk("lat_n", valid_out, 0);
      @(posedge clk); #1;
      chk("lat_n1", valid_out, 0);
      @(posedge clk); #1;
      chk("lat_n2", valid_out, 1);
      chk("white", data_out, 255);
      drain();

      send(100, 50, 200, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rgb_82", data_out, 82);
      drain();

      // credit limit with downstream stalled
      busy_in = 1'b1;
      n_acc = 0;
      for (int i = 0; i < 20; i++) begin
         data_in  = {8'(n_acc), 8'(n_acc * 3), 8'(n_acc * 10)};
         valid_in = 1'b1;
         sof_in   = (n_acc == 0);
         @(negedge clk);
         acc = !busy_out;
         @(posedge clk);
         #1;
         if (acc) begin
            model_accept(n_acc * 10, n_acc * 3, n_acc, n_acc == 0);
            n_acc++;
         end
      end
      valid_in = 1'b0;
      sof_in = 1'b0;
      chk("acc_cnt", n_acc, 8);
      chk("busy_full", busy_out, 1);
      pops0 = n_pop;
      busy_in = 1'b0;
      drain();
      chk("pop_cnt", n_pop - pops0, 8);

      // mid-frame write stays in shadow until the next sof
      send(10, 20, 30, 1'b1);
      send(40, 50, 60, 1'b0);
      coef_write(0, 255);
      coef_write(1, 255);
      coef_write(2, 0);
      coef_write(3, 7);
      send(200, 200, 0, 1'b0);
      send(200, 200, 0, 1'b1);
      send(100, 50, 200, 1'b0);
      drain();

      // write coincident with the sof accept misses that frame
      send(10, 10, 10, 1'b1, 1'b1, 0, 10);
      send(10, 10, 10, 1'b0);
      send(10, 10, 10, 1'b1);
      send(30, 40, 50, 1'b0);
      drain();

      // reset with beats buffered
      busy_in = 1'b1;
      for (int i = 0; i < 5; i++) send(i * 20, i * 7, 90, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("buffered", valid_out, 1);
      rst = 1'b1;
      #1;
      chk("rst2_valid", valid_out, 0);
      chk("rst2_sof", sof_out, 0);
      chk("rst2_data", data_out, 0);
      sb.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_valid", valid_out, 0);
      chk("post_rst_busy", busy_out, 0);
      busy_in = 1'b0;
      send(100, 50, 200, 1'b0);
      send(200, 200, 0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
